// File: rtl/collector_pkg.sv
// ============================================================================
//  Module      : collector_pkg
//  Description : Shared constants and helpers for the collector_n stream
//                collector: arbitration mode encodings and select-width
//                calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package collector_pkg;

    // Arbitration modes
    localparam int PRI_LOW  = 0;    // lowest requesting index wins
    localparam int PRI_HIGH = 1;    // highest requesting index wins
    localparam int PRI_RR   = 2;    // round-robin starting after the last winner

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of the channel select bus, never narrower than one bit
    function automatic int sel_width(input int channels);
        return (clog2(channels) > 1) ? clog2(channels) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_slice.sv
// ============================================================================
//  Module      : stream_slice
//  Description : One-stage valid/ready register slice.
//                BURST = "yes" : main + skid entry, accepts a beat every cycle
//                                while the skid entry is empty.
//                BURST = "no"  : single entry, ready only when empty, so a
//                                continuous stream runs at half rate.
//                The consumer side pops through i_pop (only while o_valid).
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst   : clock, synchronous active-high reset (empties the slice)
//    i_valid    : upstream valid
//    o_ready    : upstream ready
//    i_data     : upstream payload
//    o_valid    : slice holds a beat
//    o_data     : payload of the oldest held beat
//    i_pop      : remove the oldest beat this cycle
// ============================================================================
`default_nettype none

module stream_slice #(
    parameter int WIDTH = 33,
    parameter     BURST = "yes"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_pop
);

    logic             w_push;
    logic             r_main_vld;
    logic [WIDTH-1:0] r_main_data;

    assign w_push  = i_valid && o_ready;
    assign o_valid = r_main_vld;
    assign o_data  = r_main_data;

    generate
        if (BURST == "yes") begin : g_skid
            logic             r_skid_vld;
            logic [WIDTH-1:0] r_skid_data;

            // Ready depends only on the skid entry, so upstream never sees a
            // combinational path from the downstream pop.
            assign o_ready = !r_skid_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_main_vld <= 1'b0;
                    r_skid_vld <= 1'b0;
                end else if (i_pop && r_skid_vld) begin
                    // Skid full means input is blocked; just shift skid forward
                    r_main_data <= r_skid_data;
                    r_skid_vld  <= 1'b0;
                end else if (i_pop || !r_main_vld) begin
                    r_main_vld  <= w_push;
                    r_main_data <= i_data;
                end else if (w_push) begin
                    r_skid_vld  <= 1'b1;
                    r_skid_data <= i_data;
                end
            end
        end else begin : g_single
            assign o_ready = !r_main_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_main_vld <= 1'b0;
                end else if (i_pop) begin
                    r_main_vld <= 1'b0;
                end else if (w_push) begin
                    r_main_vld  <= 1'b1;
                    r_main_data <= i_data;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/collector_n.sv
// ============================================================================
//  Module      : collector_n
//  Description : N-channel stream collector. Each input stream is buffered in
//                its own stream_slice; an arbiter (fixed-priority low/high or
//                round-robin) picks one slice for the single output stream.
//                The grant is frozen while the output is stalled.
//                Optional packet lock: macro COLLECTOR_N_PKT_LOCK_EN.
//  Revision    : 1.0 - initial release
//
//  Ports
//    iCLK, iRST  : clock, synchronous active-high reset
//    iValid_AM   : per-channel input valid        [CHANNELS]
//    oReady_AM   : per-channel input ready        [CHANNELS]
//    iData_AM    : channel k at [k*WIDTH +: WIDTH]
//    iLast_AM    : per-channel end-of-packet (used only with packet lock)
//    oValid_BM   : output valid
//    iReady_BM   : output ready
//    oSelect_BM  : index of the channel presented
//    oData_BM    : data of the presented beat
//    oLast_BM    : last flag of the presented beat (0 without packet lock)
// ============================================================================
`default_nettype none

module collector_n
    import collector_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter     BURST    = "yes",
    parameter int PRIORITY = 2
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    input  logic [CHANNELS-1:0]            iValid_AM,
    output logic [CHANNELS-1:0]            oReady_AM,
    input  logic [CHANNELS*WIDTH-1:0]      iData_AM,
    input  logic [CHANNELS-1:0]            iLast_AM,
    output logic                           oValid_BM,
    input  logic                           iReady_BM,
    output logic [sel_width(CHANNELS)-1:0] oSelect_BM,
    output logic [WIDTH-1:0]               oData_BM,
    output logic                           oLast_BM
);

    localparam int            C_SW        = sel_width(CHANNELS);
    localparam int            C_SLICE_W   = WIDTH + 1;   // payload + last flag
    localparam logic [C_SW-1:0] C_PTR_RESET = C_SW'(CHANNELS - 1);

    logic [CHANNELS-1:0]  w_sv;
    logic [CHANNELS-1:0]  w_pop;
    logic [C_SLICE_W-1:0] w_sdata [CHANNELS];
    logic [C_SLICE_W-1:0] w_sel_word;
    logic [C_SW-1:0]      w_arb_sel;
    logic [C_SW-1:0]      w_grant;
    logic                 w_grant_vld;
    logic                 w_xfer;
    logic                 w_ptr_adv;
    logic [C_SW:0]        w_scan;
    logic [C_SW-1:0]      r_sel;
    logic [C_SW-1:0]      r_ptr;
    logic                 r_hold;

`ifdef COLLECTOR_N_PKT_LOCK_EN
    logic                 r_lock;
    logic [C_SW-1:0]      r_lock_ch;
`endif

    // ------------------------------------------------------------------
    // Per-channel input slices; the last flag travels with the payload
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_slice
            logic w_last_in;
`ifdef COLLECTOR_N_PKT_LOCK_EN
            assign w_last_in = iLast_AM[k];
`else
            assign w_last_in = 1'b0;
`endif
            stream_slice #(
                .WIDTH (C_SLICE_W),
                .BURST (BURST)
            ) u_slice (
                .clk     (iCLK),
                .rst     (iRST),
                .i_valid (iValid_AM[k]),
                .o_ready (oReady_AM[k]),
                .i_data  ({w_last_in, iData_AM[k*WIDTH +: WIDTH]}),
                .o_valid (w_sv[k]),
                .o_data  (w_sdata[k]),
                .i_pop   (w_pop[k])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Free-running arbitration over the slice valids
    // ------------------------------------------------------------------
    always_comb begin
        w_arb_sel = '0;
        w_scan    = '0;
        if (PRIORITY == PRI_LOW) begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (w_sv[i]) w_arb_sel = C_SW'(i);
            end
        end else if (PRIORITY == PRI_HIGH) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_sv[i]) w_arb_sel = C_SW'(i);
            end
        end else begin
            // Scan from pointer+CHANNELS down to pointer+1 (mod CHANNELS) so
            // the final hit is the first requester above the pointer.
            for (int i = CHANNELS; i >= 1; i--) begin
                w_scan = {1'b0, r_ptr} + (C_SW+1)'(i);
                if (w_scan >= (C_SW+1)'(CHANNELS)) begin
                    w_scan = w_scan - (C_SW+1)'(CHANNELS);
                end
                if (w_sv[w_scan[C_SW-1:0]]) w_arb_sel = w_scan[C_SW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant: a stalled beat keeps its grant; a locked packet owns the output
    // ------------------------------------------------------------------
    always_comb begin
        w_grant     = w_arb_sel;
        w_grant_vld = |w_sv;
        if (r_hold) begin
            w_grant     = r_sel;
            w_grant_vld = w_sv[r_sel];
        end
`ifdef COLLECTOR_N_PKT_LOCK_EN
        if (r_lock) begin
            w_grant     = r_lock_ch;
            w_grant_vld = w_sv[r_lock_ch];
        end
`endif
    end

    assign oValid_BM  = w_grant_vld;
    assign oSelect_BM = w_grant_vld ? w_grant : r_sel;
    assign w_sel_word = w_sdata[oSelect_BM];
    assign oData_BM   = w_sel_word[WIDTH-1:0];
    assign w_xfer     = oValid_BM && iReady_BM;
    assign w_pop      = w_xfer ? (CHANNELS'(1) << w_grant) : '0;

`ifdef COLLECTOR_N_PKT_LOCK_EN
    assign oLast_BM  = w_sel_word[WIDTH];
    // Inside a packet the pointer waits for the closing beat
    assign w_ptr_adv = w_sel_word[WIDTH];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
        end else if (w_xfer) begin
            r_lock    <= !w_sel_word[WIDTH];
            r_lock_ch <= w_grant;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^{iLast_AM, w_sel_word[WIDTH]};
    assign oLast_BM      = 1'b0;
    assign w_ptr_adv     = 1'b1;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_sel  <= '0;
            r_ptr  <= C_PTR_RESET;
            r_hold <= 1'b0;
        end else begin
            r_sel  <= oSelect_BM;
            r_hold <= oValid_BM && !iReady_BM;
            if (w_xfer && w_ptr_adv) begin
                r_ptr <= w_grant;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_collector_n.sv
// ============================================================================
//  Module      : tb_collector_n
//  Description : Self-checking bench for collector_n. Three instances share
//                one stimulus: round-robin/burst, lowest-index/burst and
//                round-robin/half-rate. Directed scenarios plus a random run
//                checked against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collector_n;
    import collector_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   valid_i;
    logic [127:0] data_i;
    logic [3:0]   last_i;
    logic         ready_i;

    logic [3:0]   ready_o [3];
    logic         valid_o [3];
    logic [1:0]   sel_o   [3];
    logic [31:0]  data_o  [3];
    logic         last_o  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    collector_n #(.WIDTH(32), .CHANNELS(4), .BURST("yes"), .PRIORITY(PRI_RR)) dut_rr (
        .iCLK(clk), .iRST(rst), .iValid_AM(valid_i), .oReady_AM(ready_o[0]),
        .iData_AM(data_i), .iLast_AM(last_i), .oValid_BM(valid_o[0]),
        .iReady_BM(ready_i), .oSelect_BM(sel_o[0]), .oData_BM(data_o[0]),
        .oLast_BM(last_o[0]));

    collector_n #(.WIDTH(32), .CHANNELS(4), .BURST("yes"), .PRIORITY(PRI_LOW)) dut_lo (
        .iCLK(clk), .iRST(rst), .iValid_AM(valid_i), .oReady_AM(ready_o[1]),
        .iData_AM(data_i), .iLast_AM(last_i), .oValid_BM(valid_o[1]),
        .iReady_BM(ready_i), .oSelect_BM(sel_o[1]), .oData_BM(data_o[1]),
        .oLast_BM(last_o[1]));

    collector_n #(.WIDTH(32), .CHANNELS(4), .BURST("no"), .PRIORITY(PRI_RR)) dut_nb (
        .iCLK(clk), .iRST(rst), .iValid_AM(valid_i), .oReady_AM(ready_o[2]),
        .iData_AM(data_i), .iLast_AM(last_i), .oValid_BM(valid_o[2]),
        .iReady_BM(ready_i), .oSelect_BM(sel_o[2]), .oData_BM(data_o[2]),
        .oLast_BM(last_o[2]));

    // ------------------------------------------------------------------
    // Reference model: each slice is a FIFO of {last,data}; capacity 2 for
    // burst slices, 1 for half-rate slices.
    // ------------------------------------------------------------------
    logic [32:0] mq [3][4][$];
    int          m_mode  [3] = '{2, 0, 2};
    int          m_cap   [3] = '{2, 2, 1};
    int          m_ptr   [3];
    int          m_lastsel [3];
    int          m_hsel  [3];
    bit          m_hold  [3];
    bit          m_lock  [3];
    int          m_lock_ch [3];
    bit          ev_valid [3];
    int          ev_sel   [3];
    logic [3:0]  ev_ready [3];

    function automatic int arb(input int mode, input logic [3:0] sv, input int ptr);
        if (mode == 0) begin
            for (int k = 0; k < 4; k++) if (sv[k]) return k;
        end else if (mode == 1) begin
            for (int k = 3; k >= 0; k--) if (sv[k]) return k;
        end else begin
            for (int j = 1; j <= 4; j++) if (sv[(ptr + j) % 4]) return (ptr + j) % 4;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) mq[d][k].delete();
            m_ptr[d] = 3; m_lastsel[d] = 0; m_hsel[d] = 0;
            m_hold[d] = 0; m_lock[d] = 0; m_lock_ch[d] = 0;
        end
    endtask

    task automatic model_eval(input int d);
        logic [3:0] sv;
        int         sel;
        for (int k = 0; k < 4; k++) begin
            sv[k]          = (mq[d][k].size() != 0);
            ev_ready[d][k] = (mq[d][k].size() < m_cap[d]);
        end
        if (m_hold[d]) begin
            sel = m_hsel[d];
            ev_valid[d] = sv[sel];
        end else begin
            sel = arb(m_mode[d], sv, m_ptr[d]);
            ev_valid[d] = |sv;
        end
        if (m_lock[d]) begin
            sel = m_lock_ch[d];
            ev_valid[d] = sv[sel];
        end
        ev_sel[d] = ev_valid[d] ? sel : m_lastsel[d];
    endtask

    // Advance the model across the coming clock edge using current inputs
    task automatic model_step(input int d);
        logic [32:0] item;
        if (ev_valid[d] && ready_i) begin
            item = mq[d][ev_sel[d]].pop_front();
`ifdef COLLECTOR_N_PKT_LOCK_EN
            m_lock[d]    = !item[32];
            m_lock_ch[d] = ev_sel[d];
            if (item[32]) m_ptr[d] = ev_sel[d];
`else
            m_ptr[d] = ev_sel[d];
`endif
        end
        m_hold[d]    = ev_valid[d] && !ready_i;
        m_hsel[d]    = ev_sel[d];
        m_lastsel[d] = ev_sel[d];
        for (int k = 0; k < 4; k++) begin
            if (valid_i[k] && ev_ready[d][k]) mq[d][k].push_back({last_i[k], data_i[k*32 +: 32]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_i = '0; last_i = '0; data_i = '0; ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (valid_o[d] !== 1'b0) begin errors++; $display("FAIL reset_valid dut%0d: got %b want 0", d, valid_o[d]); end
            checks++; if (ready_o[d] !== 4'hF) begin errors++; $display("FAIL reset_ready dut%0d: got %b want 1111", d, ready_o[d]); end
            checks++; if (sel_o[d] !== 2'd0) begin errors++; $display("FAIL reset_select dut%0d: got %0d want 0", d, sel_o[d]); end
        end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        valid_i = 4'b0100; data_i[64 +: 32] = 32'hA5; ready_i = 1'b1;
        tick();
        valid_i = '0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (valid_o[d] !== 1'b1) begin errors++; $display("FAIL single_valid dut%0d: got %b want 1", d, valid_o[d]); end
            checks++; if (sel_o[d] !== 2'd2) begin errors++; $display("FAIL single_select dut%0d: got %0d want 2", d, sel_o[d]); end
            checks++; if (data_o[d] !== 32'hA5) begin errors++; $display("FAIL single_data dut%0d: got %h want a5", d, data_o[d]); end
        end
        tick();
        @(negedge clk);
        checks++; if (valid_o[0] !== 1'b0) begin errors++; $display("FAIL single_drained: got %b want 0", valid_o[0]); end
        tick();
    endtask

    task automatic test_round_robin();
        int cnt [4];
        int served [4];
        int exp_sel;
        do_reset();
        for (int k = 0; k < 4; k++) begin cnt[k] = 0; served[k] = 0; end
        ready_i = 1'b1; valid_i = 4'hF;
        for (int c = 0; c < 9; c++) begin
            for (int k = 0; k < 4; k++) data_i[k*32 +: 32] = 32'(k * 256 + cnt[k] + 1);
            @(negedge clk);
            if (c == 0) begin
                checks++; if (valid_o[0] !== 1'b0) begin errors++; $display("FAIL rr_first_valid: got %b want 0", valid_o[0]); end
            end else begin
                exp_sel = (c - 1) % 4;
                checks++; if (valid_o[0] !== 1'b1) begin errors++; $display("FAIL rr_valid cyc%0d: got %b want 1", c, valid_o[0]); end
                checks++; if (sel_o[0] !== 2'(exp_sel)) begin errors++; $display("FAIL rr_select cyc%0d: got %0d want %0d", c, sel_o[0], exp_sel); end
                checks++; if (data_o[0] !== 32'(exp_sel * 256 + served[exp_sel] + 1)) begin
                    errors++; $display("FAIL rr_data cyc%0d: got %h want %h", c, data_o[0], 32'(exp_sel * 256 + served[exp_sel] + 1));
                end
                served[exp_sel]++;
            end
            for (int k = 0; k < 4; k++) if (ready_o[0][k]) cnt[k]++;
            tick();
        end
        valid_i = '0;
    endtask

    task automatic test_stall_hold();
        do_reset();
        ready_i = 1'b0; valid_i = 4'b1000; data_i[96 +: 32] = 32'h3333;
        tick();
        for (int s = 0; s < 5; s++) begin
            if (s == 1) begin valid_i = 4'b0001; data_i[0 +: 32] = 32'h1111; end
            else valid_i = '0;
            @(negedge clk);
            checks++; if (valid_o[1] !== 1'b1) begin errors++; $display("FAIL hold_valid s%0d: got %b want 1", s, valid_o[1]); end
            checks++; if (sel_o[1] !== 2'd3) begin errors++; $display("FAIL hold_select s%0d: got %0d want 3", s, sel_o[1]); end
            checks++; if (data_o[1] !== 32'h3333) begin errors++; $display("FAIL hold_data s%0d: got %h want 3333", s, data_o[1]); end
            tick();
        end
        valid_i = '0; ready_i = 1'b1;
        @(negedge clk);
        checks++; if (sel_o[1] !== 2'd3) begin errors++; $display("FAIL release_select: got %0d want 3", sel_o[1]); end
        tick();
        @(negedge clk);
        checks++; if (valid_o[1] !== 1'b1) begin errors++; $display("FAIL after_valid: got %b want 1", valid_o[1]); end
        checks++; if (sel_o[1] !== 2'd0) begin errors++; $display("FAIL after_select: got %0d want 0", sel_o[1]); end
        checks++; if (data_o[1] !== 32'h1111) begin errors++; $display("FAIL after_data: got %h want 1111", data_o[1]); end
        tick();
    endtask

    task automatic test_half_rate();
        do_reset();
        ready_i = 1'b1; valid_i = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            data_i[32 +: 32] = 32'(c);
            @(negedge clk);
            checks++; if (ready_o[2][1] !== 1'((c % 2) == 0)) begin errors++; $display("FAIL half_ready cyc%0d: got %b want %b", c, ready_o[2][1], (c % 2) == 0); end
            checks++; if (valid_o[2] !== 1'((c % 2) == 1)) begin errors++; $display("FAIL half_valid cyc%0d: got %b want %b", c, valid_o[2], (c % 2) == 1); end
            checks++; if (ready_o[0][1] !== 1'b1) begin errors++; $display("FAIL burst_ready cyc%0d: got %b want 1", c, ready_o[0][1]); end
            if (c > 0) begin
                checks++; if (valid_o[0] !== 1'b1) begin errors++; $display("FAIL burst_valid cyc%0d: got %b want 1", c, valid_o[0]); end
            end
            tick();
        end
        valid_i = '0;
    endtask

`ifdef COLLECTOR_N_PKT_LOCK_EN
    task automatic test_lock();
        int rec_sel [$];
        bit rec_last [$];
        int exp_sel [4]  = '{1, 1, 1, 0};
        bit exp_last [4] = '{0, 0, 1, 0};
        do_reset();
        ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            valid_i[1] = (c < 3); last_i[1] = (c == 2); data_i[32 +: 32] = 32'h100 + 32'(c);
            valid_i[0] = (c >= 1); last_i[0] = 1'b0;    data_i[0 +: 32]  = 32'h200 + 32'(c);
            @(negedge clk);
            if (valid_o[0]) begin rec_sel.push_back(int'(sel_o[0])); rec_last.push_back(last_o[0]); end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= rec_sel.size()) begin
                errors++; $display("FAIL lock_seq beat%0d: got none want sel %0d", i, exp_sel[i]);
            end else if (rec_sel[i] != exp_sel[i] || rec_last[i] != exp_last[i]) begin
                errors++; $display("FAIL lock_seq beat%0d: got sel %0d last %0d want sel %0d last %0d", i, rec_sel[i], rec_last[i], exp_sel[i], exp_last[i]);
            end
        end
        valid_i = '0; last_i = '0;
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        ready_i = 1'b0; valid_i = 4'b0111;
        for (int k = 0; k < 4; k++) data_i[k*32 +: 32] = 32'hDEAD0000 + 32'(k);
        tick();
        valid_i = '0;
        tick();
        @(negedge clk);
        checks++; if (valid_o[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", valid_o[0]); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            ready_i = (s > 0);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++; if (valid_o[d] !== 1'b0) begin errors++; $display("FAIL post_reset_valid dut%0d s%0d: got %b want 0", d, s, valid_o[d]); end
            end
            tick();
        end
    endtask

    task automatic test_random(input int ncyc);
        logic [32:0] item;
        logic        exp_last;
        do_reset();
        model_reset();
        for (int c = 0; c < ncyc; c++) begin
            valid_i = 4'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            last_i  = 4'($urandom);
            for (int k = 0; k < 4; k++) data_i[k*32 +: 32] = $urandom;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                model_eval(d);
                checks++; if (ready_o[d] !== ev_ready[d]) begin errors++; $display("FAIL rand_ready dut%0d cyc%0d: got %b want %b", d, c, ready_o[d], ev_ready[d]); end
                checks++; if (valid_o[d] !== ev_valid[d]) begin errors++; $display("FAIL rand_valid dut%0d cyc%0d: got %b want %b", d, c, valid_o[d], ev_valid[d]); end
                checks++; if (sel_o[d] !== 2'(ev_sel[d])) begin errors++; $display("FAIL rand_select dut%0d cyc%0d: got %0d want %0d", d, c, sel_o[d], ev_sel[d]); end
                if (ev_valid[d]) begin
                    item = mq[d][ev_sel[d]][0];
`ifdef COLLECTOR_N_PKT_LOCK_EN
                    exp_last = item[32];
`else
                    exp_last = 1'b0;
`endif
                    checks++; if (data_o[d] !== item[31:0]) begin errors++; $display("FAIL rand_data dut%0d cyc%0d: got %h want %h", d, c, data_o[d], item[31:0]); end
                    checks++; if (last_o[d] !== exp_last) begin errors++; $display("FAIL rand_last dut%0d cyc%0d: got %b want %b", d, c, last_o[d], exp_last); end
                end
                model_step(d);
            end
            tick();
        end
        valid_i = '0;
    endtask

    initial begin
        rst = 1'b1; valid_i = '0; last_i = '0; data_i = '0; ready_i = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall_hold();
        test_half_rate();
`ifdef COLLECTOR_N_PKT_LOCK_EN
        test_lock();
`endif
        test_reset_mid();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
